// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - reads 16-bit words from a FIFO and sends them as two UART bytes, low byte first
// Define UART_TX_PARITY_EN to insert an even-parity bit after each data byte.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fifo_empty,
  input  logic [15:0] fifo_data,
  output logic        fifo_read,
  output logic        tx,
  output logic        busy,
  output logic        word_done
);

  localparam logic [15:0] BIT_LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, RD, LATCH, START, DATA, PAR, STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        byte_sel_q, byte_sel_d;
  logic [15:0] word_q, word_d;
  logic        tx_q, tx_d;
  logic        fifo_read_q, fifo_read_d;
  logic        busy_q, busy_d;
  logic        word_done_q, word_done_d;
  logic        bit_end;
  logic [7:0]  cur_byte;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    byte_sel_d = byte_sel_q;
    word_d     = word_q;
    bit_end    = (cnt_q == 16'd0);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = RD;
      end
      RD: state_d = LATCH;
      LATCH: begin
        word_d     = fifo_data;
        byte_sel_d = 1'b0;
        cnt_d      = BIT_LAST;
        state_d    = START;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = 3'd0;
          cnt_d   = BIT_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = BIT_LAST;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PAR;
`else
            state_d = STOP;
`endif
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = BIT_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (!byte_sel_q) begin
            // Byte 1 starts straight after byte 0's stop bit
            byte_sel_d = 1'b1;
            cnt_d      = BIT_LAST;
            state_d    = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it once registered
    cur_byte    = byte_sel_d ? word_d[15:8] : word_d[7:0];
    fifo_read_d = (state_d == RD);
    busy_d      = (state_d != IDLE);
    word_done_d = (state_q == STOP) && (state_d == IDLE);

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[idx_d];
      PAR:     tx_d = ^cur_byte;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 16'd0;
      idx_q       <= 3'd0;
      byte_sel_q  <= 1'b0;
      word_q      <= 16'd0;
      tx_q        <= 1'b1;
      fifo_read_q <= 1'b0;
      busy_q      <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_sel_q  <= byte_sel_d;
      word_q      <= word_d;
      tx_q        <= tx_d;
      fifo_read_q <= fifo_read_d;
      busy_q      <= busy_d;
      word_done_q <= word_done_d;
    end
  end

  assign fifo_read = fifo_read_q;
  assign tx        = tx_q;
  assign busy      = busy_q;
  assign word_done = word_done_q;

endmodule
